formula_clause_loader: RTL and testbench
========================================

// Module: formula_clause_loader
// PURPOSE
// Writer side of the clause-register bus: accepts a formula one clause per handshake and drives index/coeff/write-enable into
// the per-clause integer+boolean clause registers, pads unused slots with zeros, and builds the per-clause checker-enable mask
// consumed by the unsatisfied-clause selector. Sits between the host/setup stream and the stochastic-search clause bank.
// PARAMETERS
// MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT     4  bitwidth of one integer coeff (also bias)
// MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT     2  bitwidth of one boolean coeff (always 2: {exist,value})
// MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX  1  log2 integer variables per clause
// MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX  1  log2 boolean variables per clause
// MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX           2  log2 clause slots (N = 2**value)
// PORTS  (IW=(2**INT_VAR_IDX+1)*INT_COEFF, BW=2**BOOL_VAR_IDX*BOOL_COEFF, CI=CLAUSES_INDEX, N=2**CI)
// in_clk                           in   1     clock
// in_reset                         in   1     asynchronous, active-low reset
// in_start                         in   1     begin a load; sampled only in IDLE
// in_num_clauses                   in   CI+1  clauses to load, legal 1..N; sampled with in_start
// in_valid                         in   1     clause word valid
// out_ready                        out  1     loader accepts clause word
// in_clause_coefficients_integer   in   IW    integer coeffs + bias of incoming clause
// in_clause_coefficients_boolean   in   BW    boolean coeffs of incoming clause
// out_clause_coefficients_integer  out  IW    to clause registers
// out_clause_coefficients_boolean  out  BW    to clause registers
// out_clause_index                 out  CI    slot being written
// out_write_enable                 out  1     one-cycle write strobe for out_clause_index
// out_checker_enable               out  N     bit i=1 iff slot i holds a loaded clause
// out_busy / out_done / out_error  out  1     load active / 1-cycle completion pulse / sticky bad count
// out_checksum                     out  IW+BW XOR of all accepted clause words (see CONFIGURATION)
// BEHAVIOUR
// - Reset (in_reset=0, async): state=IDLE; all outputs 0, out_checker_enable=0, counter=0.
// - FSM: IDLE -> LOAD (in_start & 1<=in_num_clauses<=N) | DONE (in_start & illegal count: out_error=1, no writes).
//   LOAD -> PAD when accepted count reaches in_num_clauses and count<N; LOAD -> DONE when count reaches N.
//   PAD -> DONE after last slot N-1 written. DONE -> IDLE unconditionally (1 cycle).
// - out_ready=1 only in LOAD and only while count<num_clauses; combinational from state/count, never from in_valid.
// - Handshake: transfer when in_valid&out_ready at posedge. Data/index/write strobe registered: out_write_enable high the
//   cycle after transfer, index=count at transfer, coeffs=accepted word. Back-to-back transfers => back-to-back strobes.
// - in_valid low in LOAD: wait, out_write_enable=0, no timeout.
// - PAD: one slot per cycle, coeffs=0, index=num_clauses..N-1, out_write_enable=1.
// - out_checker_enable: cleared on accepted in_start; bit i set on same edge as slot i's loaded-clause write strobe. Never set
//   for padded slots. Holds after DONE until next accepted in_start or reset.
// - out_done: 1 in DONE (one cycle), also for error. out_busy=1 in LOAD/PAD.
// - out_error: set on illegal count, cleared on next legal accepted in_start or reset.
// - in_start while busy ignored; no abort. Reset mid-load: everything to reset values, partial clause regs not cleared here.
// - Counter is CI+1 bits (reaches N without wrap); index out = counter[CI-1:0].
// CONFIGURATION
// - FORMULA_LOADER_CHECKSUM_EN defined: out_checksum cleared on accepted in_start, XOR-accumulates {int,bool} of each
//   accepted word (padding excluded); valid from DONE onward, holds until next start.
// - Not defined: no accumulator; out_checksum tied to 0.
// TESTING  (defaults: N=4, IW=12, BW=4)
// - Reset: drive in_reset=0 mid-LOAD -> all outputs 0 same cycle, state IDLE; in_valid afterward gives out_ready=0.
// - Full load: start num=4, words 0x123/0x1,0x456/0x2,0x789/0x3,0xABC/0x0 continuous valid -> strobes idx 0..3 on 4 consecutive
//   cycles, mask=4'b1111, out_done 1 cycle after last strobe, no PAD writes.
// - Partial+pad: num=2, valid with 1-cycle gaps -> idx0,idx1 with data, then idx2,idx3 with 0; mask=4'b0011; done once.
// - Illegal: num=0 and num=5 -> no strobe, out_error=1, out_done pulse; next start num=1 clears error.
// - Busy start: pulse in_start num=1 during LOAD of num=3 -> ignored, exactly 3 data writes + 1 pad.
// - Checksum (macro on): words 0x123/0x1, 0x456/0x2 -> out_checksum={0x575,0x3}; macro off -> 0.

Source files
------------

// File: rtl/formula_clause_loader.sv
`default_nettype none
// ============================================================================
// Module      : formula_clause_loader
// Description : Writer side of the clause-register bus. Accepts a formula one
//               clause per valid/ready handshake, drives index / coefficients /
//               write strobe into the clause registers, pads the unused slots
//               with zero clauses and builds the per-clause checker-enable mask.
//               Optional macro FORMULA_LOADER_CHECKSUM_EN adds an XOR checksum
//               of all accepted clause words; without it out_checksum is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module formula_clause_loader #(
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2,
  // Derived widths: integer word carries 2**idx coefficients plus the bias.
  localparam int IW = (2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX + 1) *
                      MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
  localparam int BW = (2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX) *
                      MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT,
  localparam int CI = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int N  = 2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX
) (
  input  logic              in_clk,
  input  logic              in_reset,
  input  logic              in_start,
  input  logic [CI:0]       in_num_clauses,
  input  logic              in_valid,
  output logic              out_ready,
  input  logic [IW-1:0]     in_clause_coefficients_integer,
  input  logic [BW-1:0]     in_clause_coefficients_boolean,
  output logic [IW-1:0]     out_clause_coefficients_integer,
  output logic [BW-1:0]     out_clause_coefficients_boolean,
  output logic [CI-1:0]     out_clause_index,
  output logic              out_write_enable,
  output logic [N-1:0]      out_checker_enable,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_error,
  output logic [IW+BW-1:0]  out_checksum
);

  // Counter constants; the counter is one bit wider than the index so it can
  // hold the value N without wrapping.
  localparam logic [CI:0] c_one     = {{CI{1'b0}}, 1'b1};
  localparam logic [CI:0] c_n_slots = {1'b1, {CI{1'b0}}};
  localparam logic [CI:0] c_last    = c_n_slots - c_one;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CI:0]      r_count;
  logic [CI:0]      r_num;
  logic [IW-1:0]    r_coeff_int;
  logic [BW-1:0]    r_coeff_bool;
  logic [CI-1:0]    r_index;
  logic             r_we;
  logic [N-1:0]     r_mask;
  logic             r_error;

  logic             w_ready;
  logic             w_xfer;
  logic             w_start_ok;
  logic             w_num_legal;

  // Ready depends only on state and count so the source may hold valid
  // without creating a combinational loop through the handshake.
  assign w_ready     = (r_state == S_LOAD) && (r_count < r_num);
  assign w_xfer      = in_valid && w_ready;
  assign w_start_ok  = (r_state == S_IDLE) && in_start;
  assign w_num_legal = (in_num_clauses != {(CI+1){1'b0}}) &&
                       (in_num_clauses <= c_n_slots);

  // Main control FSM; all bus outputs are registered here.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_num        <= '0;
      r_coeff_int  <= '0;
      r_coeff_bool <= '0;
      r_index      <= '0;
      r_we         <= 1'b0;
      r_mask       <= '0;
      r_error      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_start) begin
            // A new load invalidates the previous formula's mask.
            r_mask <= '0;
            if (w_num_legal) begin
              r_state <= S_LOAD;
              r_count <= '0;
              r_num   <= in_num_clauses;
              r_error <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_error <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (w_xfer) begin
            r_we                       <= 1'b1;
            r_index                    <= r_count[CI-1:0];
            r_coeff_int                <= in_clause_coefficients_integer;
            r_coeff_bool               <= in_clause_coefficients_boolean;
            r_mask[r_count[CI-1:0]]    <= 1'b1;
            r_count                    <= r_count + c_one;
          end else if (r_count == r_num) begin
            // Leaving one cycle after the last transfer keeps done strictly
            // behind the last data strobe.
            if (r_count == c_n_slots) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_PAD;
            end
          end
        end

        S_PAD: begin
          // Zero clauses fill the remaining slots; mask bits stay clear.
          r_we         <= 1'b1;
          r_index      <= r_count[CI-1:0];
          r_coeff_int  <= '0;
          r_coeff_bool <= '0;
          r_count      <= r_count + c_one;
          if (r_count == c_last) begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_ready                       = w_ready;
  assign out_busy                        = (r_state == S_LOAD) || (r_state == S_PAD);
  assign out_done                        = (r_state == S_DONE);
  assign out_error                       = r_error;
  assign out_write_enable                = r_we;
  assign out_clause_index                = r_index;
  assign out_clause_coefficients_integer = r_coeff_int;
  assign out_clause_coefficients_boolean = r_coeff_bool;
  assign out_checker_enable              = r_mask;

`ifdef FORMULA_LOADER_CHECKSUM_EN
  logic [IW+BW-1:0] r_checksum;

  // XOR accumulator over accepted words only; padding never contributes.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum ^ {in_clause_coefficients_integer,
                                  in_clause_coefficients_boolean};
    end
  end

  assign out_checksum = r_checksum;
`else
  assign out_checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_formula_clause_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_formula_clause_loader
// Description : Scoreboard bench for formula_clause_loader. A driver issues
//               loads and pushes the expected write / completion records; a
//               negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_formula_clause_loader;

  localparam int CI = 2;
  localparam int N  = 4;
  localparam int IW = 12;
  localparam int BW = 4;
`ifdef FORMULA_LOADER_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_start;
  logic [CI:0]       in_num;
  logic              in_valid;
  logic              out_ready;
  logic [IW-1:0]     in_ci;
  logic [BW-1:0]     in_cb;
  logic [IW-1:0]     out_ci;
  logic [BW-1:0]     out_cb;
  logic [CI-1:0]     out_idx;
  logic              out_we;
  logic [N-1:0]      out_mask;
  logic              out_busy;
  logic              out_done;
  logic              out_error;
  logic [IW+BW-1:0]  out_cks;

  always #5 clk = ~clk;

  formula_clause_loader dut (
    .in_clk                          (clk),
    .in_reset                        (rst_n),
    .in_start                        (in_start),
    .in_num_clauses                  (in_num),
    .in_valid                        (in_valid),
    .out_ready                       (out_ready),
    .in_clause_coefficients_integer  (in_ci),
    .in_clause_coefficients_boolean  (in_cb),
    .out_clause_coefficients_integer (out_ci),
    .out_clause_coefficients_boolean (out_cb),
    .out_clause_index                (out_idx),
    .out_write_enable                (out_we),
    .out_checker_enable              (out_mask),
    .out_busy                        (out_busy),
    .out_done                        (out_done),
    .out_error                       (out_error),
    .out_checksum                    (out_cks)
  );

  typedef struct packed {
    logic [CI-1:0] idx;
    logic [IW-1:0] ci;
    logic [BW-1:0] cb;
    logic          data;
  } wr_t;

  typedef struct packed {
    logic             err;
    logic [N-1:0]     mask;
    logic [IW+BW-1:0] cks;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  strobe_cyc[$];
  int  done_cyc;
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  bit  prev_done = 1'b0;

  logic [IW-1:0] words_i[N];
  logic [BW-1:0] words_b[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, got, exp);
    end
  endtask

  // Monitor: compares every write strobe and completion pulse against the queues.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_we) begin
        wr_t w;
        strobe_cyc.push_back(cyc);
        if (wq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write got idx=%0d required=no_write", out_idx);
        end else begin
          w = wq.pop_front();
          check("wr_index", 32'(out_idx), 32'(w.idx));
          check("wr_coeff_int", 32'(out_ci), 32'(w.ci));
          check("wr_coeff_bool", 32'(out_cb), 32'(w.cb));
          check("mask_at_strobe", 32'(out_mask[out_idx]), 32'(w.data));
        end
      end
      if (out_done) begin
        dn_t d;
        done_cyc = cyc;
        check("done_single_cycle", 32'(prev_done), 32'd0);
        check("writes_before_done", 32'(wq.size()), 32'd0);
        check("busy_in_done", 32'(out_busy), 32'd0);
        if (dq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done got=1 required=0");
        end else begin
          d = dq.pop_front();
          check("done_error", 32'(out_error), 32'(d.err));
          check("done_mask", 32'(out_mask), 32'(d.mask));
          check("done_checksum", 32'(out_cks), 32'(d.cks));
        end
      end
      prev_done = out_done;
    end
  end

  // Driver plus reference model: the expected result of a load follows
  // directly from the count and the words offered.
  task automatic run_load(input int num, input int gap_mode, input bit busy_start);
    bit               legal;
    logic [IW+BW-1:0] x;
    bit               got_done;
    legal = (num >= 1) && (num <= N);
    x = '0;
    if (legal) begin
      for (int i = 0; i < N; i++) begin
        if (i < num) begin
          wq.push_back('{idx: CI'(i), ci: words_i[i], cb: words_b[i], data: 1'b1});
          x = x ^ {words_i[i], words_b[i]};
        end else begin
          wq.push_back('{idx: CI'(i), ci: '0, cb: '0, data: 1'b0});
        end
      end
      dq.push_back('{err: 1'b0, mask: N'((1 << num) - 1), cks: (CKS_EN ? x : '0)});
    end else begin
      dq.push_back('{err: 1'b1, mask: '0, cks: '0});
    end

    in_start = 1'b1;
    in_num   = (CI+1)'(num);
    @(posedge clk); #1;
    in_start = 1'b0;

    if (legal) begin
      for (int k = 0; k < num; k++) begin
        int  g;
        bit  hs;
        g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
        if (g > 0) begin
          in_valid = 1'b0;
          repeat (g) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_ci    = words_i[k];
        in_cb    = words_b[k];
        if (busy_start && k == 1) begin
          in_start = 1'b1;
          in_num   = (CI+1)'(1);
        end
        hs = 1'b0;
        for (int t = 0; t < 20 && !hs; t++) begin
          @(negedge clk);
          hs = out_ready;
          @(posedge clk); #1;
        end
        in_start = 1'b0;
        if (!hs) begin
          n_tests++;
          n_fail++;
          $display("FAIL handshake_timeout got=no_ready required=ready word=%0d", k);
        end
      end
      in_valid = 1'b0;
    end

    got_done = 1'b0;
    for (int t = 0; t < 40 && !got_done; t++) begin
      @(negedge clk);
      got_done = out_done;
    end
    if (!got_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout got=0 required=1");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_start = 1'b0;
    in_num   = '0;
    in_valid = 1'b0;
    in_ci    = '0;
    in_cb    = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(out_ready), 32'd0);
    check("rst_busy", 32'(out_busy), 32'd0);
    check("rst_done", 32'(out_done), 32'd0);
    check("rst_error", 32'(out_error), 32'd0);
    check("rst_we", 32'(out_we), 32'd0);
    check("rst_mask", 32'(out_mask), 32'd0);
    check("rst_cks", 32'(out_cks), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Full load, continuous valid: four back-to-back strobes, no padding.
    words_i[0] = 12'h123; words_b[0] = 4'h1;
    words_i[1] = 12'h456; words_b[1] = 4'h2;
    words_i[2] = 12'h789; words_b[2] = 4'h3;
    words_i[3] = 12'hABC; words_b[3] = 4'h0;
    strobe_cyc.delete();
    run_load(4, 0, 1'b0);
    check("full_strobe_count", 32'(strobe_cyc.size()), 32'd4);
    if (strobe_cyc.size() == 4) begin
      for (int i = 0; i < 3; i++)
        check("full_back_to_back", 32'(strobe_cyc[i+1] - strobe_cyc[i]), 32'd1);
      check("full_done_after_last", 32'(done_cyc - strobe_cyc[3]), 32'd1);
    end
    check("mask_holds_idle", 32'(out_mask), 32'hF);

    // Partial load with gaps; also the fixed checksum pair.
    run_load(2, 1, 1'b0);
    check("partial_mask", 32'(out_mask), 32'h3);
    check("checksum_hold", 32'(out_cks), CKS_EN ? 32'h5753 : 32'h0);

    // Illegal counts, then a legal start clears the error.
    run_load(0, 0, 1'b0);
    check("error_sticky_0", 32'(out_error), 32'd1);
    run_load(5, 0, 1'b0);
    check("error_sticky_5", 32'(out_error), 32'd1);
    words_i[0] = 12'h5A5; words_b[0] = 4'h9;
    run_load(1, 0, 1'b0);
    check("error_cleared", 32'(out_error), 32'd0);

    // Start pulse during a busy load is ignored.
    for (int i = 0; i < N; i++) begin
      words_i[i] = IW'($urandom);
      words_b[i] = BW'($urandom);
    end
    run_load(3, 0, 1'b1);

    // Randomized loads.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) begin
        words_i[i] = IW'($urandom);
        words_b[i] = BW'($urandom);
      end
      run_load(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 1'($urandom));
    end

    // Asynchronous reset in the middle of a load.
    mon_en = 1'b0;
    in_start = 1'b1;
    in_num   = (CI+1)'(4);
    @(posedge clk); #1;
    in_start = 1'b0;
    in_valid = 1'b1;
    in_ci    = 12'hFFF;
    in_cb    = 4'hF;
    @(posedge clk); #1;
    check("midload_busy", 32'(out_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(out_busy), 32'd0);
    check("arst_ready", 32'(out_ready), 32'd0);
    check("arst_we", 32'(out_we), 32'd0);
    check("arst_mask", 32'(out_mask), 32'd0);
    check("arst_idx_data", 32'({out_idx, out_ci, out_cb}), 32'd0);
    check("arst_cks", 32'(out_cks), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(out_ready), 32'd0);
    check("post_rst_done", 32'(out_done), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    check("wq_empty", 32'(wq.size()), 32'd0);
    check("dq_empty", 32'(dq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
